sram_port_arbiter: RTL



---
 rtl/mem_arb_pkg.sv | 34 +++
 rtl/req_slot.sv | 31 +++
 rtl/sram_port_arbiter_checker.sv | 34 +++
 rtl/sram_port_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the SRAM/TLB port arbiter: error flags, FSM states and
// the captured data-request record.
package mem_arb_pkg;

    // Widest address the captured data request can hold.
    localparam int ARB_ADDR_W = 32;

    typedef struct packed {
        logic tlb_invalid;
        logic tlb_miss;
        logic addr_error;
    } mem_err_t;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_ISSUE_I = 3'd1,
        ARB_ISSUE_D = 3'd2,
        ARB_WAIT_I  = 3'd3,
        ARB_WAIT_D  = 3'd4
    } arb_state_e;

    typedef struct packed {
        logic                  we;
        logic [3:0]            wstrb;
        logic [ARB_ADDR_W-1:0] addr;
        logic [31:0]           wdata;
    } data_req_t;

    // True while a granted request is waiting for its response strobe.
    function automatic logic is_wait_state(arb_state_e s);
        return (s == ARB_WAIT_I) || (s == ARB_WAIT_D);
    endfunction

endpackage

// File: rtl/req_slot.sv
// One-entry request holding register. A new request (set) wins over a flush
// in the same cycle, because the flush only cancels older requests.
module req_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         set,
    input  logic         clear,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic         valid,
    output logic [W-1:0] dout
);

    // Capture on set, drop the entry on clear or flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (set) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (clear || flush) begin
            valid <= 1'b0;
        end else begin
            valid <= valid;
        end
    end

endmodule

// File: rtl/sram_port_arbiter_checker.sv
// Protocol checks for the port arbiter: one outstanding request per
// requester, and memory responses only while a grant is waiting for one.
module sram_port_arbiter_checker
    import mem_arb_pkg::*;
(
    input logic       clk,
    input logic       reset,
    input arb_state_e state,
    input logic       inst_req,
    input logic       inst_flush,
    input logic       data_req,
    input logic       mem_rvalid,
    input logic       inst_slot_valid,
    input logic       data_slot_valid,
    input logic       drop
);

    a_inst_one_outstanding: assert property (@(posedge clk) disable iff (reset)
        !(inst_req && !inst_flush &&
          (inst_slot_valid || (state == ARB_ISSUE_I) ||
           ((state == ARB_WAIT_I) && !mem_rvalid && !drop))))
        else $error("instruction request while one is still outstanding");

    a_data_one_outstanding: assert property (@(posedge clk) disable iff (reset)
        !(data_req &&
          (data_slot_valid || (state == ARB_ISSUE_D) ||
           ((state == ARB_WAIT_D) && !mem_rvalid))))
        else $error("data request while one is still outstanding");

    a_rvalid_in_wait: assert property (@(posedge clk) disable iff (reset)
        !(mem_rvalid && !is_wait_state(state)))
        else $error("memory response with no request waiting");

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one memory/TLB port between instruction fetch and data access.
// Data wins by default; after DATA_STREAK_MAX data grants with fetch waiting,
// fetch is forced through. Fetch flush cancels the queued fetch and discards
// any fetch response already in flight.
module sram_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_STREAK_MAX = 4,
    parameter int ADDR_W          = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_flush,
    output logic              inst_valid,
    output logic [31:0]       inst_rdata,
    output logic [2:0]        inst_err,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_valid,
    output logic [31:0]       data_rdata,
    output logic [2:0]        data_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    input  logic [2:0]        mem_err
);

    localparam int STREAK_W = $clog2(DATA_STREAK_MAX + 1);
    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(DATA_STREAK_MAX);

    arb_state_e          state_r, state_s;
    logic [STREAK_W-1:0] streak_r;
    logic                drop_r;
    logic                grant_i_s, grant_d_s;
    logic                inst_pend_s, data_pend_s;
    logic                inst_set_s, data_set_s;
    logic                inst_slot_valid, data_slot_valid;
    logic [ADDR_W-1:0]   inst_slot_addr, inst_cand_addr_s;
    data_req_t           data_in_s, data_slot_req, data_cand_s;
    logic                inst_valid_s, data_valid_s;
    mem_err_t            resp_err_s;

    // A request arriving in IDLE is granted directly (bypassing its slot),
    // so the first mem_req appears the cycle after the req pulse.
    assign data_in_s        = {data_we, data_wstrb, ARB_ADDR_W'(data_addr), data_wdata};
    assign inst_cand_addr_s = inst_req ? inst_addr : inst_slot_addr;
    assign data_cand_s      = data_req ? data_in_s : data_slot_req;
    assign inst_pend_s      = inst_req || (inst_slot_valid && !inst_flush);
    assign data_pend_s      = data_req || data_slot_valid;
    assign inst_set_s       = inst_req && !grant_i_s;
    assign data_set_s       = data_req && !grant_d_s;

    // The slots hold only requests that have not been granted yet; the
    // granted one lives in the mem_* registers until its handshake.
    req_slot #(.W(ADDR_W)) u_inst_slot (
        .clk   (clk),
        .reset (reset),
        .set   (inst_set_s),
        .clear (grant_i_s),
        .flush (inst_flush),
        .din   (inst_addr),
        .valid (inst_slot_valid),
        .dout  (inst_slot_addr)
    );

    req_slot #(.W($bits(data_req_t))) u_data_slot (
        .clk   (clk),
        .reset (reset),
        .set   (data_set_s),
        .clear (grant_d_s),
        .flush (1'b0),
        .din   (data_in_s),
        .valid (data_slot_valid),
        .dout  (data_slot_req)
    );

    // Next-state and grant decision.
    always_comb begin
        state_s   = state_r;
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        case (state_r)
            ARB_IDLE: begin
                if (inst_pend_s && ((streak_r == STREAK_LIMIT) || !data_pend_s)) begin
                    grant_i_s = 1'b1;
                    state_s   = ARB_ISSUE_I;
                end else if (data_pend_s) begin
                    grant_d_s = 1'b1;
                    state_s   = ARB_ISSUE_D;
                end else begin
                    state_s   = ARB_IDLE;
                end
            end
            ARB_ISSUE_I: begin
                if (mem_ready) state_s = ARB_WAIT_I;
                else           state_s = ARB_ISSUE_I;
            end
            ARB_ISSUE_D: begin
                if (mem_ready) state_s = ARB_WAIT_D;
                else           state_s = ARB_ISSUE_D;
            end
            ARB_WAIT_I: begin
                if (mem_rvalid) state_s = ARB_IDLE;
                else            state_s = ARB_WAIT_I;
            end
            ARB_WAIT_D: begin
                if (mem_rvalid) state_s = ARB_IDLE;
                else            state_s = ARB_WAIT_D;
            end
            default: state_s = ARB_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_r <= ARB_IDLE;
        else       state_r <= state_s;
    end

    // Count data grants that overtook a waiting fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_r <= '0;
        end else if (grant_i_s || !inst_pend_s) begin
            streak_r <= '0;
        end else if (grant_d_s && (streak_r != STREAK_LIMIT)) begin
            streak_r <= streak_r + STREAK_W'(1);
        end else begin
            streak_r <= streak_r;
        end
    end

    // Remember that the fetch currently on the port was flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_r <= 1'b0;
        end else if ((state_r == ARB_WAIT_I) && mem_rvalid) begin
            drop_r <= 1'b0;
        end else if (inst_flush && ((state_r == ARB_ISSUE_I) || (state_r == ARB_WAIT_I))) begin
            drop_r <= 1'b1;
        end else begin
            drop_r <= drop_r;
        end
    end

    // Memory request registers: loaded on grant, held until mem_ready.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'h0;
            mem_addr  <= '0;
            mem_wdata <= 32'h0;
        end else if (grant_i_s) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_wstrb <= 4'h0;
            mem_addr  <= inst_cand_addr_s;
            mem_wdata <= 32'h0;
        end else if (grant_d_s) begin
            mem_req   <= 1'b1;
            mem_we    <= data_cand_s.we;
            mem_wstrb <= data_cand_s.wstrb;
            mem_addr  <= data_cand_s.addr[ADDR_W-1:0];
            mem_wdata <= data_cand_s.wdata;
        end else if (mem_req && mem_ready) begin
            mem_req   <= 1'b0;
        end else begin
            mem_req   <= mem_req;
        end
    end

    // Responses are steered to their owner in the cycle they arrive.
    assign resp_err_s   = mem_err;
    assign inst_valid_s = (state_r == ARB_WAIT_I) && mem_rvalid && !drop_r;
    assign data_valid_s = (state_r == ARB_WAIT_D) && mem_rvalid;
    assign inst_valid   = inst_valid_s;
    assign data_valid   = data_valid_s;
    assign inst_rdata   = inst_valid_s ? mem_rdata : 32'h0;
    assign data_rdata   = data_valid_s ? mem_rdata : 32'h0;
    assign inst_err     = inst_valid_s ? resp_err_s : 3'b000;
    assign data_err     = data_valid_s ? resp_err_s : 3'b000;

    sram_port_arbiter_checker u_checker (
        .clk             (clk),
        .reset           (reset),
        .state           (state_r),
        .inst_req        (inst_req),
        .inst_flush      (inst_flush),
        .data_req        (data_req),
        .mem_rvalid      (mem_rvalid),
        .inst_slot_valid (inst_slot_valid),
        .data_slot_valid (data_slot_valid),
        .drop            (drop_r)
    );

endmodule
